// File: rtl/core_pipe_pkg.sv
// Shared pipeline-control types: sequencer states, the bundled stage strobes
// and a constructor for them.
package core_pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        LOAD_STALL = 2'd2,
        MEM_WAIT   = 2'd3
    } ctrl_state_e;

    localparam int REG_ADDR_W_DEF = 5;
    localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t make_ctrl(
        input logic pc_en,
        input logic if_id_en,
        input logic if_id_flush,
        input logic id_ex_en,
        input logic id_ex_flush,
        input logic ex_mem_en
    );
        pipe_ctrl_t c;
        c.pc_en       = pc_en;
        c.if_id_en    = if_id_en;
        c.if_id_flush = if_id_flush;
        c.id_ex_en    = id_ex_en;
        c.id_ex_flush = id_ex_flush;
        c.ex_mem_en   = ex_mem_en;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX load
// destination; x0 never produces a hazard.
module hazard_detect
    import core_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    output logic                  o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_nonzero = (i_ex_rd != REG_ADDR_W'(REG_ZERO));
    assign w_rs1_hit    = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: prioritised stall/flush strobes for the PC, IF/ID,
// ID/EX and EX/MEM registers, a stall-reason FSM and a sticky stall watchdog.
module pipe_hazard_ctrl
    import core_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_STALL  = 15,
    parameter int CNT_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_redirect,
    input  logic                  i_imem_ready,
    input  logic                  i_dmem_busy,
    output logic                  o_pc_en,
    output logic                  o_if_id_en,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_en,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_en,
    output logic                  o_stall_timeout,
    output logic [1:0]            o_ctrl_state
);

    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_next;
    logic             r_stall_timeout;
    logic             w_load_use_raw;
    logic             w_load_use;
    logic             w_wait_active;
    pipe_ctrl_t       w_ctrl_rule;
    pipe_ctrl_t       w_ctrl;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_ex_rd       (i_ex_rd),
        .i_ex_mem_read (i_ex_mem_read),
        .o_load_use    (w_load_use_raw)
    );

    // The cycle after a load stall the EX slot holds the bubble, so the
    // comparator is ignored once to guarantee exactly one bubble.
    assign w_load_use = w_load_use_raw && (r_state != LOAD_STALL);

    // Priority resolution: mem busy, redirect, load-use, fetch wait, run.
    always_comb begin
        w_next_state  = RUN;
        w_wait_active = 1'b0;
        w_ctrl_rule   = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        if (i_dmem_busy) begin
            w_next_state  = MEM_WAIT;
            w_wait_active = 1'b1;
            w_ctrl_rule   = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (i_ex_redirect) begin
            w_next_state  = RUN;
            w_ctrl_rule   = make_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end else if (w_load_use) begin
            w_next_state  = LOAD_STALL;
            w_ctrl_rule   = make_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        end else if (!i_imem_ready) begin
            w_next_state  = FETCH_WAIT;
            w_wait_active = 1'b1;
            w_ctrl_rule   = make_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        end else begin
            w_next_state  = RUN;
            w_wait_active = 1'b0;
            w_ctrl_rule   = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        end
    end

    // Reset overrides the strobes immediately: everything held, both stages bubbled.
    always_comb begin
        w_ctrl = w_ctrl_rule;
        if (i_rst) begin
            w_ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            w_ctrl = w_ctrl_rule;
        end
    end

    // Saturating wait counter; a switch between wait classes keeps counting.
    always_comb begin
        w_stall_cnt_next = '0;
        if (w_wait_active) begin
            if (r_stall_cnt == STALL_LIMIT) begin
                w_stall_cnt_next = r_stall_cnt;
            end else begin
                w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
            end
        end else begin
            w_stall_cnt_next = '0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            if (w_stall_cnt_next == STALL_LIMIT) begin
                r_stall_timeout <= 1'b1;
            end else begin
                r_stall_timeout <= r_stall_timeout;
            end
        end
    end

    assign o_pc_en         = w_ctrl.pc_en;
    assign o_if_id_en      = w_ctrl.if_id_en;
    assign o_if_id_flush   = w_ctrl.if_id_flush;
    assign o_id_ex_en      = w_ctrl.id_ex_en;
    assign o_id_ex_flush   = w_ctrl.id_ex_flush;
    assign o_ex_mem_en     = w_ctrl.ex_mem_en;
    assign o_stall_timeout = r_stall_timeout;
    assign o_ctrl_state    = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a rule-table
// reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       uses_rs1, uses_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_busy;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic       stall_timeout;
    logic [1:0] ctrl_state;
    logic [5:0] out_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: last rule code, consecutive wait count, sticky flag
    int m_state = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    always #5 clk = ~clk;

    assign out_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MAX_STALL(15), .CNT_W(8)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_uses_rs1   (uses_rs1),
        .i_id_uses_rs2   (uses_rs2),
        .i_ex_rd         (ex_rd),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_redirect   (ex_redirect),
        .i_imem_ready    (imem_ready),
        .i_dmem_busy     (dmem_busy),
        .o_pc_en         (pc_en),
        .o_if_id_en      (if_id_en),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_en      (id_ex_en),
        .o_id_ex_flush   (id_ex_flush),
        .o_ex_mem_en     (ex_mem_en),
        .o_stall_timeout (stall_timeout),
        .o_ctrl_state    (ctrl_state)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // 0 RUN, 1 FETCH_WAIT, 2 LOAD_STALL, 3 MEM_WAIT, 4 REDIRECT
    function automatic int model_rule();
        bit hazard;
        hazard = ex_mem_read && (ex_rd != 5'd0) &&
                 ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd)) &&
                 (m_state != 2);
        if (dmem_busy)        return 3;
        else if (ex_redirect) return 4;
        else if (hazard)      return 2;
        else if (!imem_ready) return 1;
        else                  return 0;
    endfunction

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
    function automatic logic [5:0] rule_outs(input int r);
        case (r)
            1:       return 6'b011101;
            2:       return 6'b000111;
            3:       return 6'b000000;
            4:       return 6'b111111;
            default: return 6'b110101;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_to    = 1'b0;
    endtask

    // inputs are already applied (just after an edge); check, clock, update model
    task automatic step(input string tag);
        int r;
        logic [5:0] exp;
        #1;
        r   = model_rule();
        exp = rst ? 6'b001010 : rule_outs(r);
        check_val({tag, "/strobes"}, 8'(out_vec), 8'(exp));
        check_val({tag, "/state"}, 8'(ctrl_state), 8'(m_state));
        check_val({tag, "/timeout"}, 8'(stall_timeout), 8'(m_to));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_state = (r == 4) ? 0 : r;
            if (r == 1 || r == 3) begin
                if (m_cnt < 15) m_cnt++;
            end else begin
                m_cnt = 0;
            end
            if (m_cnt == 15) m_to = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        uses_rs1 = 1'b0; uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("run");

        // x0 is never a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; uses_rs1 = 1'b1;
        step("x0_guard");
        check_val("x0_pc_en", 8'(pc_en), 8'd1);

        // single load-use bubble, then the masked cycle with inputs still matching
        ex_rd = 5'd5; id_rs1 = 5'd5;
        step("load_use");
        step("load_use_mask");
        check_val("lu_state", 8'(ctrl_state), 8'd0);
        ex_mem_read = 1'b0;
        step("after_lu");

        // rs1 and rs2 both matching still yields one bubble
        ex_mem_read = 1'b1; uses_rs2 = 1'b1; id_rs2 = 5'd5;
        step("dual_match");
        step("dual_mask");
        ex_mem_read = 1'b0;
        step("dual_after");

        // redirect wins over load-use
        ex_mem_read = 1'b1; ex_redirect = 1'b1; imem_ready = 1'b0;
        step("redir_lu");
        idle_inputs();
        step("redir_lu_next");

        // redirect deferred by dmem busy for three cycles
        ex_redirect = 1'b1; dmem_busy = 1'b1;
        repeat (3) step("redir_busy");
        dmem_busy = 1'b0;
        step("redir_release");
        check_val("redir_flush", 8'({if_id_flush, id_ex_flush}), 8'd3);
        idle_inputs();
        step("idle");

        // asynchronous reset in the middle of a MEM_WAIT stall
        dmem_busy = 1'b1;
        repeat (7) step("busy7");
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst/strobes", 8'(out_vec), 8'(6'b001010));
        check_val("async_rst/state", 8'(ctrl_state), 8'd0);
        model_reset();
        step("rst_hold");
        rst = 1'b0;
        idle_inputs();
        step("post_rst");

        // random traffic with small register indices to provoke matches
        for (int i = 0; i < 400; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            uses_rs1    = 1'($urandom_range(0, 1));
            uses_rs2    = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 99) < 50);
            ex_redirect = ($urandom_range(0, 99) < 15);
            imem_ready  = ($urandom_range(0, 99) >= 25);
            dmem_busy   = ($urandom_range(0, 99) < 20);
            step("random");
        end

        // fresh reset, then watchdog boundary: 14 waits stay clear, 15 trip it
        idle_inputs();
        rst = 1'b1;
        step("wd_rst");
        rst = 1'b0;
        step("wd_run");
        imem_ready = 1'b0;
        repeat (14) step("wd14");
        imem_ready = 1'b1;
        step("wd14_end");
        check_val("wd14_timeout", 8'(stall_timeout), 8'd0);
        imem_ready = 1'b0;
        repeat (7) step("wd_fetch");
        dmem_busy = 1'b1;
        repeat (8) step("wd_mem");
        dmem_busy = 1'b0;
        imem_ready = 1'b1;
        step("wd15_end");
        check_val("wd15_timeout", 8'(stall_timeout), 8'd1);
        repeat (3) step("wd_sticky");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates per-stage enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers, and resolves four conditions:
- load-use hazards
- EX-stage control-flow redirects
- instruction-fetch wait
- data-memory busy stalls
A registered FSM tracks the stall reason. A watchdog counter flags stalls that last too long.

Parameters:
REG_ADDR_W, 5, register-file address width
MAX_STALL, 15, consecutive wait cycles (fetch or dmem) before stall_timeout sets; legal range 1..255
CNT_W, 8, stall counter width; must satisfy 2**CNT_W > MAX_STALL

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
imem_ready  in  1  fetch data valid this cycle
dmem_busy  in  1  data memory cannot complete the MEM-stage access
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads a NOP/bubble
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX loads a bubble
ex_mem_en  out  1  EX/MEM load enable
stall_timeout  out  1  sticky watchdog flag
ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, stall_cnt=0, stall_timeout=0.
  - While rst is high, outputs are forced: all *_en=0, if_id_flush=1, id_ex_flush=1.
- Outputs are combinational from the inputs and the current state, with zero latency. Rules are evaluated in priority order; the first match wins.
  1. dmem_busy=1 (MEM_WAIT):
     - Freeze: pc_en = if_id_en = id_ex_en = ex_mem_en = 0; no flushes.
     - Redirect and load-use are deferred. Their inputs stay stable because the pipeline is frozen.
  2. ex_redirect=1 (REDIRECT):
     - pc_en=1 (PC loads the target), if_id_flush=1, id_ex_flush=1, all enables=1.
     - Overrides load-use and imem_ready=0, since the ID/IF contents are wrong-path.
  3. load_use (LOAD_STALL):
     - load_use = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
     - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
  4. imem_ready=0 (FETCH_WAIT):
     - pc_en=0, if_id_flush=1; downstream enables=1 so older instructions drain.
  5. Otherwise (RUN): all enables=1, no flushes.
- FSM, encoded RUN=0, FETCH_WAIT=1, LOAD_STALL=2, MEM_WAIT=3:
  - Next state is the rule matched this cycle. REDIRECT maps to RUN.
  - In LOAD_STALL, load_use is masked for exactly one cycle. This guarantees a single bubble even if ex_mem_read glitches high from the bubble.
- Watchdog:
  - stall_cnt increments on each cycle where rule 1 or rule 4 is active, and saturates at MAX_STALL.
  - It clears to 0 on any cycle where neither rule is active.
  - stall_timeout sets when stall_cnt reaches MAX_STALL and stays high until rst.
  - The stall-class switch FETCH_WAIT→MEM_WAIT does not clear the counter.
- x0 is never a hazard source. A simultaneous rs1 and rs2 match still gives one bubble.

Decomposition:
- Shared package core_pipe_pkg holds:
  - enum ctrl_state_e {RUN, FETCH_WAIT, LOAD_STALL, MEM_WAIT}
  - localparam REG_ZERO = '0
  - struct pipe_ctrl_t bundling the six enable/flush outputs, so downstream registers take one port
- Sub-module hazard_detect: purely combinational load_use comparator, reused later by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, ctrl_state=2. Next cycle (EX bubble) all enables=1.
- Redirect during load-use: ex_redirect=1 with the load-use condition above → pc_en=1, if_id_flush=1, id_ex_flush=1, ctrl_state next=0.
- Redirect with dmem_busy=1 for 3 cycles → all enables=0 for 3 cycles. The flushes then assert in cycle 4 when dmem_busy drops.
- Watchdog: MAX_STALL=15, imem_ready=0 for 15 cycles → stall_timeout rises at the 15th cycle edge and stays 1 after imem_ready returns. With 14 cycles it stays 0.
- x0 guard: ex_rd=0, id_rs1=0, ex_mem_read=1 → no stall, all enables=1.
- Reset mid-stall: assert rst during MEM_WAIT with stall_cnt=7 → outputs forced immediately (asynchronous). After release: ctrl_state=0, stall_timeout=0, and a fresh 15-cycle stall is needed to trip the watchdog.
